// File: rtl/tpu_result_drain_pkg.sv
// Shared types and helpers for the result-drain path (results SRAM -> beat stream).
package tpu_result_drain_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } drain_state_e;

    localparam int DEF_MATRIX_SIZE    = 64;
    localparam int DEF_PARTIAL_SUM_BW = 24;
    localparam int DEF_LANES_PER_BEAT = 4;

    localparam int BEATS_PER_ROW = DEF_MATRIX_SIZE / DEF_LANES_PER_BEAT;
    localparam int ROW_W         = DEF_PARTIAL_SUM_BW * DEF_MATRIX_SIZE;
    localparam int BEAT_W        = DEF_PARTIAL_SUM_BW * DEF_LANES_PER_BEAT;

    // Counter width for v states; never below one bit so a 1-beat row still has a counter.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tpu_result_drain_serializer.sv
// Holds one result row and slices it into LANES_PER_BEAT-wide beats, lane 0 in the LSBs.
module result_row_serializer
    import tpu_result_drain_pkg::*;
#(
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int LANES_PER_BEAT = DEF_LANES_PER_BEAT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     load_i,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]    row_i,
    input  logic                                     send_i,
    input  logic                                     adv_i,
    output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] out_data_o,
    output logic                                     row_end_o
);

    localparam int BEATS = MATRIX_SIZE / LANES_PER_BEAT;
    localparam int BW    = clog2_min1(BEATS);
    localparam int RW    = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int OW    = PARTIAL_SUM_BW * LANES_PER_BEAT;

    logic [RW-1:0] row_buf_q;
    logic [BW-1:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_buf_q  <= '0;
            beat_cnt_q <= '0;
        end else if (load_i) begin
            row_buf_q  <= row_i;
            beat_cnt_q <= '0;
        end else if (adv_i) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    assign out_data_o = row_buf_q[beat_cnt_q*OW +: OW];
    assign row_end_o  = send_i && (beat_cnt_q == BW'(BEATS - 1));

endmodule

// File: rtl/tpu_result_drain.sv
// Drains completed result rows from the results SRAM and streams them out as narrow beats.
module tpu_result_drain
    import tpu_result_drain_pkg::*;
#(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int LANES_PER_BEAT = DEF_LANES_PER_BEAT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [ADDRESSSIZE-1:0]                   base_addr,
    input  logic [ADDRESSSIZE:0]                     num_rows,
    output logic                                     rd_en,
    output logic [ADDRESSSIZE-1:0]                   rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]    rd_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] out_data,
    output logic                                     out_row_end,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done
);

    generate
        if ((MATRIX_SIZE % LANES_PER_BEAT) != 0) begin : g_bad_lanes
            $error("LANES_PER_BEAT must divide MATRIX_SIZE");
        end
    endgenerate

    drain_state_e             state_q, state_d;
    logic [ADDRESSSIZE-1:0]   base_q, base_d;
    logic [ADDRESSSIZE:0]     num_q, num_d;
    logic [ADDRESSSIZE:0]     row_cnt_q, row_cnt_d;
    logic                     load, row_end, xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Address wraps naturally at 2^ADDRESSSIZE by truncation.
    assign rd_addr  = base_q + row_cnt_q[ADDRESSSIZE-1:0];
    assign xfer     = out_valid && out_ready;
    assign out_last = row_end && (row_cnt_q == num_q - 1'b1);
    assign out_row_end = row_end;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        row_cnt_d = row_cnt_q;
        rd_en     = 1'b0;
        load      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0) begin
                        state_d = FIN;
                    end else begin
                        base_d    = base_addr;
                        num_d     = num_rows;
                        row_cnt_d = '0;
                        state_d   = READ;
                    end
                end
            end
            READ: begin
                rd_en   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && row_end) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = out_last ? FIN : READ;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    result_row_serializer #(
        .MATRIX_SIZE   (MATRIX_SIZE),
        .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
        .LANES_PER_BEAT(LANES_PER_BEAT)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .row_i     (rd_data),
        .send_i    (out_valid),
        .adv_i     (xfer),
        .out_data_o(out_data),
        .row_end_o (row_end)
    );

endmodule
